// File: rtl/pent_pkg.sv
// Shared constants for Pentagon-style memory paging port blocks.
package pent_pkg;

    localparam int unsigned PAGE_BITS_MAX = 6;

    // Port decode: hit when (A & MASK) == VAL
    localparam logic [15:0] PORT_7FFD_MASK = 16'h8002;
    localparam logic [15:0] PORT_7FFD_VAL  = 16'h0000;
    localparam logic [15:0] PORT_EFF7_MASK = 16'hF008;
    localparam logic [15:0] PORT_EFF7_VAL  = 16'hE000;

    // Fixed RAM pages mapped into the 4000 and 8000 windows
    localparam logic [PAGE_BITS_MAX-1:0] PG_SCREEN0 = 6'd5;
    localparam logic [PAGE_BITS_MAX-1:0] PG_SCREEN1 = 6'd7;
    localparam logic [PAGE_BITS_MAX-1:0] PG_BANK2   = 6'd2;

    // Bit positions inside the 7FFD byte
    localparam int unsigned P_SCR_BIT  = 3;
    localparam int unsigned P_ROM_BIT  = 4;
    localparam int unsigned P_LOCK_BIT = 5;

    // Bit positions inside the EFF7 byte
    localparam int unsigned E_MODE_BIT = 2;
    localparam int unsigned E_RAM0_BIT = 3;

endpackage

// File: rtl/pent_io_wr_detect.sv
// Synchronises Z80 IORQ/WR/M1 and emits a one-clock pulse at the start of an I/O write.
module pent_io_wr_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic iorq_n,
    input  logic wr_n,
    input  logic m1_n,
    output logic start_c
);

    logic [1:0] iorq_sync;
    logic [1:0] wr_sync;
    logic [1:0] m1_sync;
    logic [1:0] primed;
    logic       wr_act;
    logic       wr_act_q;

    // Write active once both strobes are low and this is not an interrupt acknowledge
    assign wr_act  = ~iorq_sync[1] & ~wr_sync[1] & m1_sync[1];
    assign start_c = wr_act & ~wr_act_q;

    // Two-flop synchronisers; edge history held high until the pipeline has refilled
    // after reset so a write already in progress at release is not seen as new.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            iorq_sync <= 2'b11;
            wr_sync   <= 2'b11;
            m1_sync   <= 2'b11;
            primed    <= 2'b00;
            wr_act_q  <= 1'b1;
        end else begin
            iorq_sync <= {iorq_sync[0], iorq_n};
            wr_sync   <= {wr_sync[0], wr_n};
            m1_sync   <= {m1_sync[0], m1_n};
            primed    <= {primed[0], 1'b1};
            wr_act_q  <= wr_act | ~primed[1];
        end
    end

endmodule

// File: rtl/pent_pager.sv
// 7FFD/EFF7 memory paging registers and upper RAM address generation.
module pent_pager
    import pent_pkg::*;
#(
    parameter int unsigned PAGE_BITS  = 6,
    parameter bit          EFF7_EN    = 1'b1,
    parameter bit          RESET_1024 = 1'b0
) (
    input  logic                 CLK_14MHZ,
    input  logic                 CPU_RESET,
    input  logic [15:0]          A,
    input  logic [7:0]           D,
    input  logic                 CPU_IORQ,
    input  logic                 CPU_WR,
    input  logic                 CPU_M1,
    output logic [PAGE_BITS-1:0] MA_HI,
    output logic                 IS_ROM,
    output logic                 ROM_A14,
    output logic                 SCR_SEL,
    output logic                 LOCKED,
    output logic                 MODE_1024,
    output logic                 WR_STB
);

    logic                     start_c;
    logic                     hit_7ffd;
    logic                     hit_eff7;
    logic [7:0]               p_q;
    logic                     e_mode_q;
    logic                     ram0_q;
    logic                     lock_q;
    logic                     wr_stb_q;
    logic                     ram0;
    logic [PAGE_BITS_MAX-1:0] page_full;
    logic [PAGE_BITS-1:0]     page;

    pent_io_wr_detect u_wr_detect (
        .clk     (CLK_14MHZ),
        .rst_n   (CPU_RESET),
        .iorq_n  (CPU_IORQ),
        .wr_n    (CPU_WR),
        .m1_n    (CPU_M1),
        .start_c (start_c)
    );

    assign hit_7ffd = ((A & PORT_7FFD_MASK) == PORT_7FFD_VAL);
    assign hit_eff7 = EFF7_EN & ((A & PORT_EFF7_MASK) == PORT_EFF7_VAL);

    assign MODE_1024 = EFF7_EN & ~e_mode_q;
    assign ram0      = EFF7_EN & ram0_q;
    assign LOCKED    = lock_q;
    assign ROM_A14   = p_q[P_ROM_BIT];
    assign SCR_SEL   = p_q[P_SCR_BIT];
    assign WR_STB    = wr_stb_q;

    // Port registers: 7FFD honours the lock, EFF7 always writes and entering 1024 mode unlocks
    always_ff @(posedge CLK_14MHZ) begin
        if (!CPU_RESET) begin
            p_q      <= 8'h00;
            e_mode_q <= ~RESET_1024;
            ram0_q   <= 1'b0;
            lock_q   <= 1'b0;
            wr_stb_q <= 1'b0;
        end else begin
            wr_stb_q <= 1'b0;
            if (start_c) begin
                if (hit_7ffd && !lock_q) begin
                    p_q      <= D;
                    wr_stb_q <= 1'b1;
                    if (D[P_LOCK_BIT] && !MODE_1024) begin
                        lock_q <= 1'b1;
                    end
                end else if (hit_eff7) begin
                    e_mode_q <= D[E_MODE_BIT];
                    ram0_q   <= D[E_RAM0_BIT];
                    wr_stb_q <= 1'b1;
                    if (!D[E_MODE_BIT]) begin
                        lock_q <= 1'b0;
                    end
                end
            end
        end
    end

    // Page number: full extended bits in 1024 mode, low three bits otherwise; p itself is kept
    always_comb begin
        page_full = {3'b000, p_q[2:0]};
        if (MODE_1024) begin
            page_full = {p_q[7], p_q[6], p_q[P_LOCK_BIT], p_q[2:0]};
        end
        page = page_full[PAGE_BITS-1:0];
    end

    // CPU address window to RAM page / ROM select
    always_comb begin
        MA_HI  = '0;
        IS_ROM = 1'b0;
        unique case (A[15:14])
            2'b00:   IS_ROM = ~ram0;
            2'b01:   MA_HI  = PAGE_BITS'(PG_SCREEN0);
            2'b10:   MA_HI  = PAGE_BITS'(PG_BANK2);
            default: MA_HI  = page;
        endcase
    end

endmodule

// File: doc/pent_pager.md
Name: pent_pager

Overview:
- Parametrised successor to the fixed 128K port-7FFD logic.
- Decodes CPU I/O writes to ports 7FFD and EFF7 and holds the memory-paging state: RAM page, screen select, ROM select, lock, 1024-mode and RAM-at-0000.
- Produces the upper RAM address and ROM/RAM select for the current CPU access.
- Sits between the CPU bus pins and the MA/ROM address mux in the top level; sampled by the 14 MHz system clock.

Parameters:
- PAGE_BITS, 6, width of RAM page number (3..6; 6 = 1024K in 16K pages).
- EFF7_EN, 1, 1 = EFF7 port implemented; 0 = EFF7 writes ignored, block fixed in 128 mode.
- RESET_1024, 0, value of 1024-mode after reset (0 = 128 mode).

Ports:
- CLK_14MHZ  in  1  system clock; all state updates on rising edge.
- CPU_RESET  in  1  synchronous, active-low reset.
- A  in  16  CPU address.
- D  in  8  CPU data bus (input only).
- CPU_IORQ  in  1  Z80 IORQ, active low, asynchronous.
- CPU_WR  in  1  Z80 WR, active low, asynchronous.
- CPU_M1  in  1  Z80 M1, active low; IORQ with M1 low is INTA and is never a write.
- MA_HI  out  PAGE_BITS  RAM page for the current A[15:14].
- IS_ROM  out  1  current access targets ROM.
- ROM_A14  out  1  ROM bank select (7FFD bit 4).
- SCR_SEL  out  1  screen page select (7FFD bit 3: 0 = page 5, 1 = page 7).
- LOCKED  out  1  7FFD lock active.
- MODE_1024  out  1  1024 mode active.
- WR_STB  out  1  one-clock pulse when either port register is updated.

Behaviour:
- Synchronisation:
  - CPU_IORQ, CPU_WR and CPU_M1 each pass through a 2-flop synchroniser.
  - wr_act = ~iorq_s & ~wr_s & m1_s.
  - Edge detector: start = wr_act & ~wr_act_q.
- Capture timing:
  - A and D are sampled directly on the cycle where start is high. A Z80 I/O write holds them stable for ≥8 clocks.
  - The register updates on that same edge.
  - Latency: update occurs on the 3rd rising edge after IORQ and WR are both first low at a setup-meeting edge.
  - WR_STB is high for exactly that one cycle.
- Decode:
  - 7FFD hit = A[15]==0 & A[1]==0.
  - EFF7 hit = A[15:12]==4'hE & A[3]==0 & EFF7_EN.
  - The two hits are mutually exclusive (A15 differs).
- 7FFD register p[7:0]:
  - Written only when LOCKED==0.
  - p[2:0] = page low, p[3] = SCR_SEL, p[4] = ROM_A14.
  - p[5] sets the lock in 128 mode, or is page bit 3 in 1024 mode.
  - p[7:6] = page bits 5:4 in 1024 mode.
- EFF7 register e[3:2] (other bits ignored), written regardless of LOCKED:
  - MODE_1024 = ~e[2].
  - ram0 = e[3].
- LOCKED:
  - Set when 7FFD is written with D[5]=1 while MODE_1024==0.
  - Cleared only by reset or by an EFF7 write that enters 1024 mode.
  - Always 0 in 1024 mode.
- Page number:
  - 1024 mode: {p[7],p[6],p[5],p[2:0]} truncated to PAGE_BITS LSBs.
  - 128 mode: {zeros, p[2:0]}.
  - p itself is retained across mode changes; only the output is masked.
- Address map (combinational from registers and A[15:14]):
  - 00: IS_ROM=1, MA_HI=0. If ram0=1: IS_ROM=0, MA_HI=0.
  - 01: MA_HI=5.
  - 10: MA_HI=2.
  - 11: MA_HI=page.
- Reset (CPU_RESET low at a rising edge):
  - p=0, e[3]=0, e[2]=~RESET_1024, LOCKED=0, WR_STB=0.
  - Synchroniser flops set to the inactive level (1).
  - wr_act_q set to 1, so a write in progress at reset release is not captured.
  - Reset dominates any simultaneous start.
- A write shorter than the synchroniser window (glitch under 2 clocks) is allowed to be missed; no partial update.

Decomposition:
- Shared package pent_pkg: port match constants (7FFD/EFF7 masks and values), page constants PG_SCREEN0=5, PG_SCREEN1=7, PG_BANK2=2, and a localparam for bit positions of p and e.
- One sub-module: pent_io_wr_detect (2-flop sync of IORQ/WR/M1 plus rising-edge start pulse), reusable for later port blocks.

Test Plan:
- Reset, then A=C000 -> MA_HI=0, IS_ROM=0; A=0000 -> IS_ROM=1; LOCKED=0, MODE_1024=0, ROM_A14=0.
- OUT 7FFD,0x17 in 128 mode -> WR_STB pulse 3 clocks after IORQ/WR low; MA_HI at A=C000 = 7; ROM_A14=1; SCR_SEL=0.
- OUT 7FFD,0x20 then OUT 7FFD,0x03 -> LOCKED=1 after first write; second write produces no WR_STB and page stays 0.
- OUT EFF7,0x00 (enter 1024) then OUT 7FFD,0xE5 -> LOCKED=0, MODE_1024=1, MA_HI at C000 = 0x3D; then OUT EFF7,0x04 -> MA_HI = 5.
- OUT EFF7,0x08 -> A=0000 gives IS_ROM=0, MA_HI=0; INTA cycle (M1 and IORQ low, address 7FFD) -> no update.
- Assert CPU_RESET mid-write (IORQ/WR held low across reset release) -> registers 0 and no WR_STB after release; PAGE_BITS=3 build with OUT 7FFD,0xE5 in 1024 mode -> MA_HI=5.
